// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the multi-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int WCNT_W    = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin or fixed-priority grant selection; the pointer holds the last accepted index.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N    = 3,
    parameter int MODE = ARB_RR,
    parameter int IW   = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    // Search order starts one past the last grant; fixed mode always starts at 0.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (MODE == ARB_FIXED) ? k : int'(ptr) + 1 + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= IW'(N - 1);
        else if (advance && MODE == ARB_RR)
            ptr <= gnt_idx;
    end

endmodule

// File: rtl/sram_arb_multi.sv
// N-port arbiter onto one asynchronous SRAM with programmable read/write wait states.
//
//  state    | meaning
//  IDLE     | bus released, strobes high; arbitrate and accept one command
//  RD       | ce_n/oe_n low for RD_WAIT+1 cycles, data sampled on the last one
//  WR_SETUP | ce_n low, write data driven, we_n still high
//  WR_PULSE | we_n low for WR_WAIT+1 cycles
//  WR_HOLD  | we_n high, data still driven, then release
module sram_arb_multi
    import sram_arb_pkg::*;
#(
    parameter int  NPORTS   = 3,
    parameter int  AW       = 20,
    parameter int  DW       = 16,
    parameter int  RD_WAIT  = 1,
    parameter int  WR_WAIT  = 1,
    parameter int  ARB_MODE = ARB_RR,
    localparam int BW       = DW / 8,
    localparam int IW       = $clog2(NPORTS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NPORTS*AW-1:0] p_address,
    input  logic [NPORTS*BW-1:0] p_byteenable,
    input  logic [NPORTS-1:0]    p_read,
    input  logic [NPORTS-1:0]    p_write,
    input  logic [NPORTS*DW-1:0] p_writedata,
    output logic [NPORTS-1:0]    p_waitrequest,
    output logic [DW-1:0]        p_readdata,
    output logic [NPORTS-1:0]    p_readdatavalid,
    output logic [AW-1:0]        sram_address,
    inout  wire  [DW-1:0]        sram_data,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [BW-1:0]        sram_be_n
);

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     owner;
    logic [DW-1:0]     wdata_q;
    logic              drive;
    logic              accept;

    assign req    = p_read | p_write;
    assign accept = (state == IDLE) && (|req);

    rr_arbiter #(.N(NPORTS), .MODE(ARB_MODE), .IW(IW)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign p_waitrequest = accept ? ~gnt : '1;
    assign sram_data     = drive ? wdata_q : 'z;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            wcnt            <= '0;
            owner           <= '0;
            wdata_q         <= '0;
            drive           <= 1'b0;
            sram_address    <= '0;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_we_n       <= 1'b1;
            sram_be_n       <= '1;
            p_readdata      <= '0;
            p_readdatavalid <= '0;
        end else begin
            p_readdatavalid <= '0;
            case (state)
                IDLE: if (accept) begin
                    owner        <= gnt_idx;
                    sram_address <= p_address[gnt_idx*AW +: AW];
                    sram_be_n    <= ~p_byteenable[gnt_idx*BW +: BW];
                    wdata_q      <= p_writedata[gnt_idx*DW +: DW];
                    sram_ce_n    <= 1'b0;
                    // A simultaneous read+write from one port resolves to the write.
                    if (p_write[gnt_idx]) begin
                        drive <= 1'b1;
                        state <= WR_SETUP;
                    end else begin
                        sram_oe_n <= 1'b0;
                        wcnt      <= WCNT_W'(RD_WAIT);
                        state     <= RD;
                    end
                end
                RD: begin
                    if (wcnt == '0) begin
                        p_readdata             <= sram_data;
                        p_readdatavalid[owner] <= 1'b1;
                        sram_ce_n              <= 1'b1;
                        sram_oe_n              <= 1'b1;
                        sram_be_n              <= '1;
                        state                  <= IDLE;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    wcnt      <= WCNT_W'(WR_WAIT);
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (wcnt == '0) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    sram_ce_n <= 1'b1;
                    sram_be_n <= '1;
                    drive     <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always @(posedge clock) begin
        if (!reset) assert (!(|(p_read & p_write)));
    end

endmodule

// File: tb/tb_sram_arb_multi.sv
// Directed bench: four arbiter instances (RR w=1, FIXED w=1, RR w=0, RR w=3) each on its own SRAM model.
module tb_sram_arb_multi;
    import sram_arb_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [59:0] p_address [4];
    logic [5:0]  p_be      [4];
    logic [2:0]  p_read    [4];
    logic [2:0]  p_write   [4];
    logic [47:0] p_wdata   [4];
    logic [2:0]  p_wait    [4];
    logic [2:0]  p_rdv     [4];
    logic [15:0] p_rdata   [4];
    logic [19:0] s_addr    [4];
    logic        ce_n      [4];
    logic        oe_n      [4];
    logic        we_n      [4];
    logic [1:0]  be_n      [4];

    int oe_w [4];
    int we_w [4];
    int ce_w [4];
    int gap_l [4];
    int ovl [4];
    int grant_log [8];

    for (genvar i = 0; i < 4; i++) begin : g_inst
        wire  [15:0] bus;
        logic [15:0] mem [16];
        int oe_run = 0, we_run = 0, ce_run = 0, gap_run = 0;

        sram_arb_multi #(
            .NPORTS(3), .AW(20), .DW(16),
            .RD_WAIT(i == 2 ? 0 : (i == 3 ? 3 : 1)),
            .WR_WAIT(i == 2 ? 0 : (i == 3 ? 3 : 1)),
            .ARB_MODE(i == 1 ? ARB_FIXED : ARB_RR)
        ) u_dut (
            .clock           (clock),
            .reset           (reset),
            .p_address       (p_address[i]),
            .p_byteenable    (p_be[i]),
            .p_read          (p_read[i]),
            .p_write         (p_write[i]),
            .p_writedata     (p_wdata[i]),
            .p_waitrequest   (p_wait[i]),
            .p_readdata      (p_rdata[i]),
            .p_readdatavalid (p_rdv[i]),
            .sram_address    (s_addr[i]),
            .sram_data       (bus),
            .sram_ce_n       (ce_n[i]),
            .sram_oe_n       (oe_n[i]),
            .sram_we_n       (we_n[i]),
            .sram_be_n       (be_n[i])
        );

        // Async SRAM: drives on ce_n&oe_n low, captures enabled lanes while we_n is low.
        assign bus = (!ce_n[i] && !oe_n[i]) ? mem[s_addr[i][3:0]] : 16'hzzzz;
        always @(posedge clock) begin
            if (!reset && !ce_n[i] && !we_n[i]) begin
                if (!be_n[i][0]) mem[s_addr[i][3:0]][7:0]  <= bus[7:0];
                if (!be_n[i][1]) mem[s_addr[i][3:0]][15:8] <= bus[15:8];
            end
        end

        always @(negedge clock) begin
            if (!oe_n[i]) oe_run++; else if (oe_run > 0) begin oe_w[i] = oe_run; oe_run = 0; end
            if (!we_n[i]) we_run++; else if (we_run > 0) begin we_w[i] = we_run; we_run = 0; end
            if (!ce_n[i]) ce_run++; else if (ce_run > 0) begin ce_w[i] = ce_run; ce_run = 0; end
            if (ce_n[i]) gap_run++; else if (gap_run > 0) begin gap_l[i] = gap_run; gap_run = 0; end
            if (!oe_n[i] && !we_n[i]) ovl[i]++;
        end
    end

    task automatic sync();
        @(posedge clock); #1;
    endtask

    task automatic req_write(input int d, input int p, input logic [19:0] a,
                             input logic [15:0] wd, input logic [1:0] be);
        p_address[d][p*20 +: 20] = a;
        p_wdata[d][p*16 +: 16]   = wd;
        p_be[d][p*2 +: 2]        = be;
        p_write[d][p]            = 1'b1;
    endtask

    task automatic req_read(input int d, input int p, input logic [19:0] a);
        p_address[d][p*20 +: 20] = a;
        p_be[d][p*2 +: 2]        = 2'b11;
        p_read[d][p]             = 1'b1;
    endtask

    task automatic wait_accept(input int d, input int p, output int acc, output bit ok);
        ok = 0; acc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (!p_wait[d][p]) begin acc = cyc; ok = 1; break; end
        end
        sync();
        p_read[d][p]  = 1'b0;
        p_write[d][p] = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int p, output int vc,
                              output logic [15:0] data, output bit ok);
        ok = 0; vc = 0; data = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (p_rdv[d][p]) begin vc = cyc; data = p_rdata[d]; ok = 1; break; end
        end
    endtask

    task automatic wait_ce_high(input int d, output bit ok);
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (ce_n[d]) begin ok = 1; break; end
        end
        @(negedge clock);
    endtask

    task automatic do_write(input int d, input int p, input logic [19:0] a,
                            input logic [15:0] wd, input logic [1:0] be, output bit ok);
        int  acc;
        bit  ok1, ok2;
        sync();
        req_write(d, p, a, wd, be);
        wait_accept(d, p, acc, ok1);
        wait_ce_high(d, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic do_read(input int d, input int p, input logic [19:0] a,
                           output logic [15:0] data, output int lat, output bit ok);
        int acc, vc;
        bit ok1, ok2;
        sync();
        req_read(d, p, a);
        wait_accept(d, p, acc, ok1);
        wait_valid(d, p, vc, data, ok2);
        @(negedge clock);
        lat = vc - acc;
        ok  = ok1 && ok2;
    endtask

    task automatic collect_grants(input int d, input int n, output int got);
        got = 0;
        for (int k = 0; k < 300 && got < n; k++) begin
            @(negedge clock);
            if (p_wait[d] != 3'b111) begin
                for (int j = 0; j < 3; j++)
                    if (!p_wait[d][j]) begin grant_log[got] = j; break; end
                got++;
            end
        end
        sync();
        p_read[d]  = '0;
        p_write[d] = '0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (p_wait[0] !== 3'b111) begin failures++; $display("FAIL reset_waitreq got=%b exp=111", p_wait[0]); end
        checks++; if (p_rdv[0] !== 3'b000) begin failures++; $display("FAIL reset_rdvalid got=%b exp=000", p_rdv[0]); end
        checks++; if (p_rdata[0] !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", p_rdata[0]); end
        checks++; if ({ce_n[0], oe_n[0], we_n[0]} !== 3'b111) begin failures++; $display("FAIL reset_strobes got=%b exp=111", {ce_n[0], oe_n[0], we_n[0]}); end
        checks++; if (be_n[0] !== 2'b11) begin failures++; $display("FAIL reset_be_n got=%b exp=11", be_n[0]); end
        checks++; if (s_addr[0] !== 20'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", s_addr[0]); end
    endtask

    task automatic test_contention();
        int got;
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
        bit ok;
        sync();
        for (int p = 0; p < 3; p++) req_write(0, p, 20'(p + 1), 16'(16'h0100 * (p + 1)), 2'b11);
        collect_grants(0, 6, got);
        wait_ce_high(0, ok);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= got || grant_log[k] !== exp_order[k]) begin
                failures++;
                $display("FAIL rr_order[%0d] got=%0d exp=%0d (grants seen %0d)", k, (k < got) ? grant_log[k] : -1, exp_order[k], got);
            end
        end
    endtask

    task automatic test_single_port();
        logic [15:0] data;
        int lat;
        bit ok;
        do_write(0, 0, 20'hA, 16'hAABB, 2'b11, ok);
        checks++; if (!ok || ce_w[0] !== 4) begin failures++; $display("FAIL write_busy ce_low=%0d exp=4 ok=%0d", ce_w[0], ok); end
        checks++; if (we_w[0] !== 2) begin failures++; $display("FAIL write_we_width got=%0d exp=2", we_w[0]); end
        do_read(0, 0, 20'hA, data, lat, ok);
        checks++; if (!ok || data !== 16'hAABB) begin failures++; $display("FAIL single_read data=%h exp=aabb ok=%0d", data, ok); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL single_read_latency got=%0d exp=3", lat); end
        checks++; if (oe_w[0] !== 2) begin failures++; $display("FAIL read_oe_width got=%0d exp=2", oe_w[0]); end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] data;
        int lat;
        bit ok1, ok2, ok3;
        do_write(0, 1, 20'hB, 16'h1122, 2'b11, ok1);
        do_write(0, 1, 20'hB, 16'h33FF, 2'b01, ok2);
        do_read(0, 2, 20'hB, data, lat, ok3);
        checks++; if (!(ok1 && ok2 && ok3) || data !== 16'h11FF) begin failures++; $display("FAIL byte_lanes data=%h exp=11ff", data); end
    endtask

    task automatic test_turnaround();
        logic [15:0] data, rd;
        int acc, vcyc, wcyc, lat;
        bit ok, got_v, got_w;
        do_write(0, 1, 20'hC, 16'h5A5A, 2'b11, ok);
        ovl[0] = 0;
        sync();
        req_read(0, 1, 20'hC);
        wait_accept(0, 1, acc, ok);
        req_write(0, 2, 20'hD, 16'hC3C3, 2'b11);
        got_v = 0; got_w = 0; vcyc = 0; wcyc = 0; rd = '0;
        for (int k = 0; k < 60 && !got_w; k++) begin
            @(negedge clock);
            if (p_rdv[0][1]) begin got_v = 1; vcyc = cyc; rd = p_rdata[0]; end
            if (!p_wait[0][2]) begin got_w = 1; wcyc = cyc; end
        end
        sync();
        p_write[0][2] = 1'b0;
        wait_ce_high(0, ok);
        checks++; if (!got_v || rd !== 16'h5A5A) begin failures++; $display("FAIL turn_read data=%h exp=5a5a", rd); end
        checks++; if (!got_w || wcyc !== acc + 3 || vcyc !== acc + 3) begin failures++; $display("FAIL turn_accept wcyc=%0d vcyc=%0d exp=%0d", wcyc, vcyc, acc + 3); end
        checks++; if (gap_l[0] !== 1) begin failures++; $display("FAIL turn_idle_gap got=%0d exp=1", gap_l[0]); end
        checks++; if (ovl[0] !== 0) begin failures++; $display("FAIL turn_oe_we_overlap got=%0d exp=0", ovl[0]); end
        do_read(0, 0, 20'hD, data, lat, ok);
        checks++; if (!ok || data !== 16'hC3C3) begin failures++; $display("FAIL turn_write_data got=%h exp=c3c3", data); end
    endtask

    task automatic test_fixed();
        int got, acc;
        bit ok;
        sync();
        req_write(1, 0, 20'h1, 16'h0001, 2'b11);
        req_write(1, 1, 20'h2, 16'h0002, 2'b11);
        collect_grants(1, 3, got);
        wait_ce_high(1, ok);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= got || grant_log[k] !== 0) begin
                failures++;
                $display("FAIL fixed_order[%0d] got=%0d exp=0", k, (k < got) ? grant_log[k] : -1);
            end
        end
        sync();
        req_write(1, 1, 20'h2, 16'h0002, 2'b11);
        wait_accept(1, 1, acc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fixed_p1_alone accepted=%0d exp=1", ok); end
        wait_ce_high(1, ok);
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] data;
        int acc, lat, vcount;
        bit ok;
        sync();
        req_read(0, 0, 20'hA);
        wait_accept(0, 0, acc, ok);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (!ok || oe_n[0] !== 1'b0) begin failures++; $display("FAIL midrd_in_rd oe_n=%b exp=0", oe_n[0]); end
        @(negedge clock);
        checks++; if ({ce_n[0], oe_n[0], we_n[0]} !== 3'b111) begin failures++; $display("FAIL midrd_strobes got=%b exp=111", {ce_n[0], oe_n[0], we_n[0]}); end
        checks++; if (be_n[0] !== 2'b11) begin failures++; $display("FAIL midrd_be_n got=%b exp=11", be_n[0]); end
        sync();
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (p_rdv[0] != 3'b000) vcount++;
        end
        checks++; if (vcount !== 0) begin failures++; $display("FAIL midrd_no_valid got=%0d exp=0", vcount); end
        do_read(0, 0, 20'hA, data, lat, ok);
        checks++; if (!ok || data !== 16'hAABB || lat !== 3) begin failures++; $display("FAIL midrd_reread data=%h lat=%0d exp=aabb/3", data, lat); end
    endtask

    task automatic test_wait_sweep();
        logic [15:0] data, wd;
        int lat, w;
        bit ok;
        for (int d = 2; d < 4; d++) begin
            w  = (d == 2) ? 0 : 3;
            wd = 16'h9000 + 16'(d);
            do_write(d, 0, 20'h5, wd, 2'b11, ok);
            checks++; if (!ok || we_w[d] !== w + 1) begin failures++; $display("FAIL sweep%0d_we_width got=%0d exp=%0d", w, we_w[d], w + 1); end
            checks++; if (ce_w[d] !== w + 3) begin failures++; $display("FAIL sweep%0d_write_busy got=%0d exp=%0d", w, ce_w[d], w + 3); end
            do_read(d, 1, 20'h5, data, lat, ok);
            checks++; if (!ok || data !== wd) begin failures++; $display("FAIL sweep%0d_data got=%h exp=%h", w, data, wd); end
            checks++; if (lat !== w + 2) begin failures++; $display("FAIL sweep%0d_latency got=%0d exp=%0d", w, lat, w + 2); end
            checks++; if (oe_w[d] !== w + 1) begin failures++; $display("FAIL sweep%0d_oe_width got=%0d exp=%0d", w, oe_w[d], w + 1); end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 4; d++) begin
            p_address[d] = '0; p_be[d] = '0; p_read[d] = '0; p_write[d] = '0; p_wdata[d] = '0;
            oe_w[d] = 0; we_w[d] = 0; ce_w[d] = 0; gap_l[d] = 0; ovl[d] = 0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        test_reset();
        test_contention();
        test_single_port();
        test_byte_lanes();
        test_turnaround();
        test_fixed();
        test_reset_mid_read();
        test_wait_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
